// File: rtl/mp3_frame_sync.sv
// mp3_frame_sync: MPEG-1 Layer III byte-stream front end.
// Finds frame sync, validates and decodes the 4-byte header, strips the
// optional CRC word and splits each frame into side-info and main-data bytes.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   axiid/axiiv                    input byte stream (no backpressure)
//   si_axiod/si_axiov              side-info byte stream
//   md_axiod/md_axiov              main-data byte stream
//   hdr_valid                      pulse: header fields below updated
//   bitrate_index .. frame_len     decoded header fields (held until next hdr_valid)
//   crc_err                        pulse on CRC mismatch
// Optional feature: define HEADER_CRC_CHECK_EN to check the CRC-16 over header
// bytes 2-3 and the side info; otherwise crc_err is tied to 0.
module mp3_frame_sync (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  axiid,
  input  logic        axiiv,
  output logic [7:0]  si_axiod,
  output logic        si_axiov,
  output logic [7:0]  md_axiod,
  output logic        md_axiov,
  output logic        hdr_valid,
  output logic [3:0]  bitrate_index,
  output logic [1:0]  sample_rate_index,
  output logic        padding,
  output logic        protection_absent,
  output logic [1:0]  mode,
  output logic [1:0]  mode_extension,
  output logic [10:0] frame_len,
  output logic        crc_err
);

  localparam int unsigned CNT_W       = 11;
  localparam int unsigned HDR_LEN     = 4;
  localparam int unsigned CRC_LEN     = 2;
  localparam int unsigned SIDE_STEREO = 32;
  localparam int unsigned SIDE_MONO   = 17;

  typedef enum logic [2:0] {SYNC0, SYNC1, HDR2, HDR3, CRC0, CRC1, SIDE, MAIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, side_end;
  logic             pa_q, pa_d, pad_q, pad_d;
  logic [3:0]       br_q, br_d;
  logic [1:0]       sr_q, sr_d;

  logic [7:0]       si_axiod_d, md_axiod_d;
  logic             si_axiov_d, md_axiov_d, hdr_valid_d;
  logic [3:0]       bitrate_index_d;
  logic [1:0]       sample_rate_index_d, mode_d, mode_extension_d;
  logic             padding_d, protection_absent_d;
  logic [10:0]      frame_len_d;

  // floor(144000*kbps/fs) for the 14 legal bitrates and 3 sample rates
  function automatic logic [10:0] base_len(input logic [3:0] br, input logic [1:0] sr);
    logic [10:0] l441, l48, l32;
    case (br)
      4'd1:    begin l441 = 11'd104;  l48 = 11'd96;  l32 = 11'd144;  end
      4'd2:    begin l441 = 11'd130;  l48 = 11'd120; l32 = 11'd180;  end
      4'd3:    begin l441 = 11'd156;  l48 = 11'd144; l32 = 11'd216;  end
      4'd4:    begin l441 = 11'd182;  l48 = 11'd168; l32 = 11'd252;  end
      4'd5:    begin l441 = 11'd208;  l48 = 11'd192; l32 = 11'd288;  end
      4'd6:    begin l441 = 11'd261;  l48 = 11'd240; l32 = 11'd360;  end
      4'd7:    begin l441 = 11'd313;  l48 = 11'd288; l32 = 11'd432;  end
      4'd8:    begin l441 = 11'd365;  l48 = 11'd336; l32 = 11'd504;  end
      4'd9:    begin l441 = 11'd417;  l48 = 11'd384; l32 = 11'd576;  end
      4'd10:   begin l441 = 11'd522;  l48 = 11'd480; l32 = 11'd720;  end
      4'd11:   begin l441 = 11'd626;  l48 = 11'd576; l32 = 11'd864;  end
      4'd12:   begin l441 = 11'd731;  l48 = 11'd672; l32 = 11'd1008; end
      4'd13:   begin l441 = 11'd835;  l48 = 11'd768; l32 = 11'd1152; end
      4'd14:   begin l441 = 11'd1044; l48 = 11'd960; l32 = 11'd1440; end
      default: begin l441 = 11'd0;    l48 = 11'd0;   l32 = 11'd0;    end
    endcase
    case (sr)
      2'd0:    return l441;
      2'd1:    return l48;
      default: return l32;
    endcase
  endfunction

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Frame byte count at the last side-info byte (header + optional CRC + side info)
  always_comb begin
    side_end = CNT_W'(HDR_LEN)
             + (protection_absent ? CNT_W'(0) : CNT_W'(CRC_LEN))
             + ((mode == 2'b11) ? CNT_W'(SIDE_MONO) : CNT_W'(SIDE_STEREO));
  end

  // Next-state and next-output logic
  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    pa_d                = pa_q;
    br_d                = br_q;
    sr_d                = sr_q;
    pad_d               = pad_q;
    si_axiod_d          = si_axiod;
    si_axiov_d          = 1'b0;
    md_axiod_d          = md_axiod;
    md_axiov_d          = 1'b0;
    hdr_valid_d         = 1'b0;
    bitrate_index_d     = bitrate_index;
    sample_rate_index_d = sample_rate_index;
    padding_d           = padding;
    protection_absent_d = protection_absent;
    mode_d              = mode;
    mode_extension_d    = mode_extension;
    frame_len_d         = frame_len;
    if (axiiv) begin
      cnt_d = cnt_inc;
      case (state_q)
        SYNC0: begin
          if (axiid == 8'hFF) begin
            state_d = SYNC1;
            cnt_d   = CNT_W'(1);
          end
        end
        SYNC1: begin
          if ((axiid & 8'hFE) == 8'hFA) begin
            state_d = HDR2;
            pa_d    = axiid[0];
          end else if (axiid == 8'hFF) begin
            cnt_d = CNT_W'(1);
          end else begin
            state_d = SYNC0;
          end
        end
        HDR2: begin
          br_d  = axiid[7:4];
          sr_d  = axiid[3:2];
          pad_d = axiid[1];
          if (axiid[7:4] == 4'd0 || axiid[7:4] == 4'd15 || axiid[3:2] == 2'd3)
            state_d = SYNC0;
          else
            state_d = HDR3;
        end
        HDR3: begin
          // Publish all header fields together so they only change with hdr_valid
          hdr_valid_d         = 1'b1;
          bitrate_index_d     = br_q;
          sample_rate_index_d = sr_q;
          padding_d           = pad_q;
          protection_absent_d = pa_q;
          mode_d              = axiid[7:6];
          mode_extension_d    = axiid[5:4];
          frame_len_d         = base_len(br_q, sr_q) + 11'(pad_q);
          state_d             = pa_q ? SIDE : CRC0;
        end
        CRC0: state_d = CRC1;
        CRC1: state_d = SIDE;
        SIDE: begin
          si_axiov_d = 1'b1;
          si_axiod_d = axiid;
          if (cnt_inc == side_end) state_d = MAIN;
        end
        MAIN: begin
          md_axiov_d = 1'b1;
          md_axiod_d = axiid;
          if (cnt_inc == frame_len) state_d = SYNC0;
        end
        default: state_d = SYNC0;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= SYNC0;
      cnt_q             <= '0;
      pa_q              <= 1'b0;
      br_q              <= '0;
      sr_q              <= '0;
      pad_q             <= 1'b0;
      si_axiod          <= '0;
      si_axiov          <= 1'b0;
      md_axiod          <= '0;
      md_axiov          <= 1'b0;
      hdr_valid         <= 1'b0;
      bitrate_index     <= '0;
      sample_rate_index <= '0;
      padding           <= 1'b0;
      protection_absent <= 1'b0;
      mode              <= '0;
      mode_extension    <= '0;
      frame_len         <= '0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      pa_q              <= pa_d;
      br_q              <= br_d;
      sr_q              <= sr_d;
      pad_q             <= pad_d;
      si_axiod          <= si_axiod_d;
      si_axiov          <= si_axiov_d;
      md_axiod          <= md_axiod_d;
      md_axiov          <= md_axiov_d;
      hdr_valid         <= hdr_valid_d;
      bitrate_index     <= bitrate_index_d;
      sample_rate_index <= sample_rate_index_d;
      padding           <= padding_d;
      protection_absent <= protection_absent_d;
      mode              <= mode_d;
      mode_extension    <= mode_extension_d;
      frame_len         <= frame_len_d;
    end
  end

`ifdef HEADER_CRC_CHECK_EN
  logic [15:0] crc_q, crc_d, crc_word_q, crc_word_d;
  logic        chk_q, chk_d, crc_err_d;

  // CRC-16, polynomial 0x8005, one byte MSB first
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic [7:0]  d;
    logic        fb;
    r = c;
    d = b;
    for (int i = 0; i < 8; i++) begin
      fb = r[15] ^ d[7];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h8005;
      d  = {d[6:0], 1'b0};
    end
    return r;
  endfunction

  // Running CRC; compare is deferred one cycle past the last side-info output
  always_comb begin
    crc_d      = crc_q;
    crc_word_d = crc_word_q;
    chk_d      = 1'b0;
    crc_err_d  = chk_q && (crc_q != crc_word_q);
    if (axiiv) begin
      case (state_q)
        SYNC1:      crc_d = 16'hFFFF;
        HDR2, HDR3: crc_d = crc16_byte(crc_q, axiid);
        CRC0:       crc_word_d[15:8] = axiid;
        CRC1:       crc_word_d[7:0]  = axiid;
        SIDE: begin
          crc_d = crc16_byte(crc_q, axiid);
          if (cnt_inc == side_end) chk_d = !protection_absent;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q      <= 16'hFFFF;
      crc_word_q <= '0;
      chk_q      <= 1'b0;
      crc_err    <= 1'b0;
    end else begin
      crc_q      <= crc_d;
      crc_word_q <= crc_word_d;
      chk_q      <= chk_d;
      crc_err    <= crc_err_d;
    end
  end
`else
  assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_mp3_frame_sync.sv
// tb_mp3_frame_sync: randomized scoreboard bench for mp3_frame_sync.
// Frames are built from header fields; expected header/side/main events are
// queued at issue time and a negedge monitor pops and compares DUT outputs.
module tb_mp3_frame_sync;

  localparam int K_HDR = 0;
  localparam int K_SI  = 1;
  localparam int K_MD  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  axiid;
  logic        axiiv;
  logic [7:0]  si_axiod, md_axiod;
  logic        si_axiov, md_axiov, hdr_valid;
  logic [3:0]  bitrate_index;
  logic [1:0]  sample_rate_index, mode, mode_extension;
  logic        padding, protection_absent, crc_err;
  logic [10:0] frame_len;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic [3:0] br;
    logic [1:0] sr;
    logic       pad;
    logic       pa;
    logic [1:0] md;
    logic [1:0] mx;
    int         flen;
  } ev_t;

  ev_t exp_q[$];
  int  crc_exp = 0;
  int  n_checks = 0;
  int  n_pass = 0;

  int kbps_t[15] = '{0, 32, 40, 48, 56, 64, 80, 96, 112, 128, 160, 192, 224, 256, 320};
  int fs_t[3]    = '{44100, 48000, 32000};

  mp3_frame_sync dut (
    .clk(clk), .rst_n(rst_n), .axiid(axiid), .axiiv(axiiv),
    .si_axiod(si_axiod), .si_axiov(si_axiov),
    .md_axiod(md_axiod), .md_axiov(md_axiov),
    .hdr_valid(hdr_valid), .bitrate_index(bitrate_index),
    .sample_rate_index(sample_rate_index), .padding(padding),
    .protection_absent(protection_absent), .mode(mode),
    .mode_extension(mode_extension), .frame_len(frame_len), .crc_err(crc_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic pop_check(input int kind, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk($sformatf("unexpected_event_kind%0d", kind), 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", kind, e.kind);
    if (kind == K_HDR) begin
      chk("bitrate_index", bitrate_index, e.br);
      chk("sample_rate_index", sample_rate_index, e.sr);
      chk("padding", padding, e.pad);
      chk("protection_absent", protection_absent, e.pa);
      chk("mode", mode, e.md);
      chk("mode_extension", mode_extension, e.mx);
      chk("frame_len", frame_len, e.flen);
    end else begin
      chk(kind == K_SI ? "si_data" : "md_data", d, e.data);
    end
  endtask

  // Monitor: compare every presented output against the scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (si_axiov && md_axiov) chk("si_md_overlap", 1, 0);
      if (hdr_valid) pop_check(K_HDR, 8'h00);
      if (si_axiov)  pop_check(K_SI, si_axiod);
      if (md_axiov)  pop_check(K_MD, md_axiod);
      if (crc_err) begin
        chk("crc_err_expected", crc_exp > 0, 1);
        if (crc_exp > 0) crc_exp--;
      end
    end
  end

  function automatic logic [15:0] crc16(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ b[i]) r = (r << 1) ^ 16'h8005;
      else              r = r << 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] rand_data();
    return ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom);
  endfunction

  task automatic put(input logic [7:0] b, input bit allow_gap);
    axiid = b;
    axiiv = 1'b1;
    @(posedge clk);
    #1;
    axiiv = 1'b0;
    if (allow_gap && $urandom_range(3) == 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string name);
    chk(name, {si_axiod, si_axiov, md_axiod, md_axiov, hdr_valid, bitrate_index,
               sample_rate_index, padding, protection_absent, mode, mode_extension,
               frame_len, crc_err}, 0);
  endtask

  // Build one frame from header fields; cut >= 0 resets mid-MAIN at that byte
  task automatic send_frame(input logic [3:0] br, input logic [1:0] sr, input logic pad,
                            input logic pa, input logic [1:0] md, input logic [1:0] mx,
                            input bit bad_crc, input int cut);
    logic [7:0]  b2, b3, db;
    logic [7:0]  side[$];
    logic [15:0] crc, word;
    int          flen, nside, nmain;
    ev_t         e;
    flen  = (144000 * kbps_t[br]) / fs_t[sr] + int'(pad);
    nside = (md == 2'b11) ? 17 : 32;
    nmain = flen - 4 - (pa ? 0 : 2) - nside;
    b2 = {br, sr, pad, 1'($urandom_range(1))};
    b3 = {md, mx, 4'($urandom_range(15))};
    crc = 16'hFFFF;
    crc = crc16(crc, b2);
    crc = crc16(crc, b3);
    for (int i = 0; i < nside; i++) begin
      side.push_back(rand_data());
      crc = crc16(crc, side[i]);
    end
    e.kind = K_HDR; e.data = 8'h00; e.br = br; e.sr = sr; e.pad = pad;
    e.pa = pa; e.md = md; e.mx = mx; e.flen = flen;
    exp_q.push_back(e);
    put(8'hFF, 1'b1);
    put(8'hFA | {7'd0, pa}, 1'b1);
    put(b2, 1'b1);
    put(b3, 1'b1);
    if (!pa) begin
      word = bad_crc ? (crc ^ (16'(1) << $urandom_range(15))) : crc;
`ifdef HEADER_CRC_CHECK_EN
      if (bad_crc) crc_exp++;
`endif
      put(word[15:8], 1'b1);
      put(word[7:0], 1'b1);
    end
    for (int i = 0; i < nside; i++) begin
      e.kind = K_SI; e.data = side[i];
      exp_q.push_back(e);
      put(side[i], 1'b1);
    end
    for (int i = 0; i < nmain; i++) begin
      db = rand_data();
      if (i == cut) begin
        put(db, 1'b0);
        chk("md_valid_before_reset", md_axiov, 1);
        chk("md_data_before_reset", md_axiod, db);
        rst_n = 1'b0;
        #1;
        check_all_zero("outputs_in_mid_frame_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
      e.kind = K_MD; e.data = db;
      exp_q.push_back(e);
      put(db, 1'b1);
    end
  endtask

  task automatic garbage(input int n);
    for (int i = 0; i < n; i++) put(8'($urandom_range(254)), 1'b1);
  endtask

  initial begin
    axiid = 8'h00;
    axiiv = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("outputs_in_reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Stereo 128 kbps / 44.1 kHz, then padded mono, then protected good and bad CRC
    send_frame(4'd9, 2'd0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, -1);
    send_frame(4'd9, 2'd0, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, -1);
    send_frame(4'd9, 2'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, -1);
    send_frame(4'd9, 2'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, -1);

    // Garbage with a false sync, then resync on the FF FB pair
    put(8'h12, 1'b1); put(8'hFF, 1'b1); put(8'hFF, 1'b1); put(8'h00, 1'b1);
    send_frame(4'd5, 2'd0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, -1);

    // Rejected headers: bitrate_index 15 and sample_rate_index 3
    put(8'hFF, 1'b1); put(8'hFB, 1'b1); put(8'hF0, 1'b1); put(8'h00, 1'b1);
    put(8'hFF, 1'b1); put(8'hFB, 1'b1); put(8'h9C, 1'b1); put(8'h00, 1'b1);
    garbage(3);

    // Reset in the middle of MAIN, then a clean frame
    send_frame(4'd9, 2'd0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 100);
    send_frame(4'd9, 2'd0, 1'b0, 1'b1, 2'b10, 2'b11, 1'b0, -1);

    // Randomized frames with random garbage between them
    for (int f = 0; f < 20; f++) begin
      garbage($urandom_range(5));
      send_frame(4'($urandom_range(14, 1)), 2'($urandom_range(2)), 1'($urandom_range(1)),
                 1'($urandom_range(1)), 2'($urandom_range(3)), 2'($urandom_range(3)),
                 1'($urandom_range(1)), -1);
    end

    repeat (10) @(posedge clk);
    #1;
    chk("leftover_events", exp_q.size(), 0);
    chk("leftover_crc_err", crc_exp, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
